// File: rtl/packet_mem_tx_reader_if.sv
// Signal bundle between the packet-memory tx reader, its length FIFO, the SRAM and the MAC.
// The master side is the reader itself; the slave side is the surrounding environment.
interface packet_mem_tx_reader_if #(
  parameter int pDATA_WIDTH = 8,
  parameter int pFIFO_WIDTH = 11,
  parameter int pADDR_WIDTH = 12
);
  logic                   ien;
  logic                   ilen_empty;
  logic [pFIFO_WIDTH-1:0] ilen_pac;
  logic                   olen_rd;
  logic [pADDR_WIDTH-1:0] omem_addr;
  logic [pDATA_WIDTH-1:0] imem_data;
  logic [pDATA_WIDTH-1:0] otx_d;
  logic                   otx_en;
  logic                   obusy;
  logic                   oframe_done;
  logic                   oerr_len;
  logic [pADDR_WIDTH-1:0] optr_rd;

  modport master (
    input  ien, ilen_empty, ilen_pac, imem_data,
    output olen_rd, omem_addr, otx_d, otx_en, obusy, oframe_done, oerr_len, optr_rd
  );

  modport slave (
    output ien, ilen_empty, ilen_pac, imem_data,
    input  olen_rd, omem_addr, otx_d, otx_en, obusy, oframe_done, oerr_len, optr_rd
  );
endinterface

// File: rtl/packet_mem_tx_reader.sv
// Read side of the packet memory: pops frame lengths, streams the stored bytes onto a
// byte-wide transmit bus framed by preamble/SFD, and returns the freed read pointer.
module packet_mem_tx_reader #(
  parameter int pDATA_WIDTH        = 8,
  parameter int pMAX_PACKET_LENGHT = 1536,
  parameter int pFIFO_WIDTH        = $clog2(pMAX_PACKET_LENGHT),
  parameter int pDEPTH_RAM         = 2 * pMAX_PACKET_LENGHT,
  parameter int pPREAMBLE          = 7,
  parameter int pIFG               = 12
) (
  input  logic                   iclk,
  input  logic                   i_rst,
  packet_mem_tx_reader_if.master bus
);
  localparam int AW = $clog2(pDEPTH_RAM);
  localparam int CW = pFIFO_WIDTH;
  localparam logic [pDATA_WIDTH-1:0] PRE_BYTE = 'h55;
  localparam logic [pDATA_WIDTH-1:0] SFD_BYTE = 'hD5;

  // IDLE wait for length | PREAMBLE 0x55 bytes | SFD 0xD5 | DATA frame bytes | IFG idle gap
  typedef enum logic [2:0] {IDLE, PREAMBLE, SFD, DATA, IFG} state_t;
  state_t state, state_next;

  logic [CW-1:0] cnt, len_q;
  logic [AW-1:0] rptr, mem_addr, addr_inc;
  logic          len_rd, err_len, frame_done;
  logic          pop, start, discard, last, len_ok;
  logic [pDATA_WIDTH-1:0] tx_d;

  function automatic logic [AW-1:0] wrap_add(input logic [AW-1:0] base, input logic [CW-1:0] n);
    logic [AW:0] sum;
    sum = {1'b0, base} + (AW+1)'(n);
    if (sum >= (AW+1)'(pDEPTH_RAM)) sum = sum - (AW+1)'(pDEPTH_RAM);
    return sum[AW-1:0];
  endfunction

  assign len_ok   = (bus.ilen_pac != '0) && ({1'b0, bus.ilen_pac} <= (CW+1)'(pMAX_PACKET_LENGHT));
  assign addr_inc = (mem_addr == AW'(pDEPTH_RAM - 1)) ? '0 : mem_addr + AW'(1);

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    start      = 1'b0;
    discard    = 1'b0;
    last       = 1'b0;
    case (state)
      IDLE: begin
        // While a pop is in flight the FIFO head still shows the entry being removed.
        if (bus.ien && !bus.ilen_empty && !len_rd) begin
          pop = 1'b1;
          if (len_ok) begin
            start      = 1'b1;
            state_next = PREAMBLE;
          end else begin
            discard = 1'b1;
          end
        end
      end
      PREAMBLE: if (cnt == '0) state_next = SFD;
      SFD:      state_next = DATA;
      DATA: begin
        if (cnt == '0) begin
          last       = 1'b1;
          state_next = IFG;
        end
      end
      IFG:      if (cnt == '0) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge iclk or posedge i_rst) begin
    if (i_rst) begin
      state      <= IDLE;
      cnt        <= '0;
      len_q      <= '0;
      rptr       <= '0;
      mem_addr   <= '0;
      len_rd     <= 1'b0;
      err_len    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_next;
      len_rd     <= pop;
      err_len    <= discard;
      frame_done <= last;
      case (state)
        IDLE: begin
          if (start) begin
            len_q    <= bus.ilen_pac;
            mem_addr <= rptr;
            cnt      <= CW'(pPREAMBLE - 1);
          end
          if (discard) rptr <= wrap_add(rptr, bus.ilen_pac);
        end
        PREAMBLE: cnt <= cnt - CW'(1);
        SFD: begin
          // First byte address was issued during preamble; step now so DATA is gap-free.
          cnt      <= len_q - CW'(1);
          mem_addr <= addr_inc;
        end
        DATA: begin
          mem_addr <= addr_inc;
          if (last) begin
            cnt  <= CW'(pIFG - 1);
            rptr <= wrap_add(rptr, len_q);
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        IFG:     cnt <= cnt - CW'(1);
        default: cnt <= '0;
      endcase
    end
  end

  always_comb begin
    tx_d = '0;
    case (state)
      PREAMBLE: tx_d = PRE_BYTE;
      SFD:      tx_d = SFD_BYTE;
      DATA:     tx_d = bus.imem_data;
      default:  tx_d = '0;
    endcase
  end

  assign bus.otx_d       = tx_d;
  assign bus.otx_en      = (state == PREAMBLE) || (state == SFD) || (state == DATA);
  assign bus.obusy       = (state != IDLE);
  assign bus.olen_rd     = len_rd;
  assign bus.oerr_len    = err_len;
  assign bus.oframe_done = frame_done;
  assign bus.omem_addr   = mem_addr;
  assign bus.optr_rd     = rptr;
endmodule

// File: tb/tb_packet_mem_tx_reader.sv
// Scoreboard bench for packet_mem_tx_reader: a frame-level model fills expected byte/pointer
// queues as lengths are queued; a negedge monitor pops and compares what the DUT emits.
module tb_packet_mem_tx_reader;
  localparam int MAXLEN = 1536;
  localparam int DEPTH  = 3072;
  localparam int PRE    = 7;
  localparam int IFG    = 12;

  logic iclk;
  logic i_rst;

  packet_mem_tx_reader_if #(.pDATA_WIDTH(8), .pFIFO_WIDTH(11), .pADDR_WIDTH(12)) bus ();

  packet_mem_tx_reader dut (.iclk(iclk), .i_rst(i_rst), .bus(bus));

  initial iclk = 1'b0;
  always #5 iclk = ~iclk;

  logic [7:0] mem [0:DEPTH-1];
  int len_fifo[$];
  int exp_bytes[$];
  int exp_done[$];
  int exp_err[$];
  int model_rptr;
  int n_checks = 0;
  int n_fail   = 0;
  int tx_cycles = 0;
  int err_seen  = 0;
  bit pop_now;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name, input logic [31:0] act);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got %0h with nothing expected (t=%0t)", name, act, $time);
  endtask

  function automatic void refresh_fifo();
    bus.ilen_empty = (len_fifo.size() == 0);
    bus.ilen_pac   = (len_fifo.size() == 0) ? 11'd0 : 11'(len_fifo[0]);
  endfunction

  // Frame-level reference: each queued length is either discarded or sent in full, in order.
  task automatic push_len(input int l);
    len_fifo.push_back(l);
    refresh_fifo();
    if (l == 0) begin
      exp_err.push_back(model_rptr);
    end else if (l > MAXLEN) begin
      model_rptr = (model_rptr + l) % DEPTH;
      exp_err.push_back(model_rptr);
    end else begin
      for (int k = 0; k < PRE; k++) exp_bytes.push_back(8'h55);
      exp_bytes.push_back(8'hD5);
      for (int k = 0; k < l; k++) exp_bytes.push_back(int'(mem[(model_rptr + k) % DEPTH]));
      model_rptr = (model_rptr + l) % DEPTH;
      exp_done.push_back(model_rptr);
    end
  endtask

  function automatic bit all_idle();
    return exp_bytes.size() == 0 && exp_done.size() == 0 && exp_err.size() == 0 &&
           len_fifo.size() == 0 && !bus.obusy;
  endfunction

  task automatic drain(input int budget, input string name);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge iclk);
      if (all_idle()) break;
    end
    check(name, 32'(i < budget), 32'd1);
  endtask

  task automatic flush_model();
    exp_bytes.delete();
    exp_done.delete();
    exp_err.delete();
    len_fifo.delete();
    refresh_fifo();
    model_rptr = 0;
  endtask

  task automatic apply_reset();
    @(negedge iclk);
    i_rst = 1'b1;
    flush_model();
    repeat (2) @(negedge iclk);
    i_rst = 1'b0;
  endtask

  always @(posedge iclk) bus.imem_data <= mem[bus.omem_addr];

  always @(posedge iclk) begin
    pop_now = bus.olen_rd;
    #1;
    if (pop_now) begin
      if (len_fifo.size() == 0) fail_now("pop_on_empty", 32'd1);
      else void'(len_fifo.pop_front());
      refresh_fifo();
    end
  end

  always @(negedge iclk) begin
    if (!i_rst) begin
      if (bus.otx_en) begin
        tx_cycles++;
        if (exp_bytes.size() == 0) fail_now("tx_unexpected", 32'(bus.otx_d));
        else check("tx_byte", 32'(bus.otx_d), 32'(exp_bytes.pop_front()));
      end else begin
        check("idle_txd_zero", 32'(bus.otx_d), 32'd0);
      end
      if (bus.oframe_done) begin
        if (exp_done.size() == 0) fail_now("done_unexpected", 32'(bus.optr_rd));
        else check("done_ptr", 32'(bus.optr_rd), 32'(exp_done.pop_front()));
      end
      if (bus.oerr_len) begin
        err_seen++;
        if (exp_err.size() == 0) fail_now("err_unexpected", 32'(bus.optr_rd));
        else check("err_ptr", 32'(bus.optr_rd), 32'(exp_err.pop_front()));
      end
    end
  end

  initial begin
    int gap, tx0, err0, i, r;
    i_rst = 1'b1;
    bus.ien = 1'b0;
    model_rptr = 0;
    refresh_fifo();
    for (int a = 0; a < DEPTH; a++) mem[a] = 8'($urandom);
    for (int a = 0; a < 64; a++) mem[a] = 8'(a);

    repeat (3) @(negedge iclk);
    check("rst_olen_rd", 32'(bus.olen_rd), 0);
    check("rst_otx_en", 32'(bus.otx_en), 0);
    check("rst_obusy", 32'(bus.obusy), 0);
    check("rst_optr_rd", 32'(bus.optr_rd), 0);
    check("rst_omem_addr", 32'(bus.omem_addr), 0);
    check("rst_pulses", {30'd0, bus.oframe_done, bus.oerr_len}, 0);
    i_rst = 1'b0;

    // Single 64-byte frame from address 0, start latency
    push_len(64);
    repeat (2) @(negedge iclk);
    bus.ien = 1'b1;
    @(negedge iclk);
    check("t1_olen_rd_T1", 32'(bus.olen_rd), 1);
    check("t1_otx_en_T1", 32'(bus.otx_en), 1);
    check("t1_omem_addr_T1", 32'(bus.omem_addr), 0);
    drain(500, "t1_drain");
    check("t1_optr", 32'(bus.optr_rd), 64);

    // Oversize discards walk rptr to 3040, then a frame wraps the SRAM end
    push_len(2047);
    push_len(2047);
    push_len(1954);
    drain(200, "t2_discard_drain");
    check("t2_ptr_3040", 32'(bus.optr_rd), 3040);
    push_len(64);
    drain(500, "t2_drain");
    check("t2_optr_wrap", 32'(bus.optr_rd), 32);

    // Back-to-back frames: idle gap is the IFG plus one sampling cycle
    apply_reset();
    push_len(60);
    push_len(100);
    for (i = 0; i < 300; i++) begin
      @(negedge iclk);
      if (bus.oframe_done) break;
    end
    check("t3_first_done_seen", 32'(i < 300), 1);
    check("t3_first_ptr", 32'(bus.optr_rd), 60);
    gap = 0;
    for (int k = 0; k < 100; k++) begin
      if (bus.otx_en) break;
      gap++;
      @(negedge iclk);
    end
    check("t3_gap", 32'(gap), IFG + 1);
    drain(500, "t3_drain");
    check("t3_second_ptr", 32'(bus.optr_rd), 160);

    // Illegal lengths: zero and oversize
    apply_reset();
    tx0  = tx_cycles;
    err0 = err_seen;
    push_len(0);
    push_len(1600);
    drain(100, "t4_drain");
    check("t4_no_tx", 32'(tx_cycles - tx0), 0);
    check("t4_err_count", 32'(err_seen - err0), 2);
    check("t4_ptr", 32'(bus.optr_rd), 1600);

    // ien gating: no start while low, no effect when dropped mid-frame
    bus.ien = 1'b0;
    push_len(40);
    repeat (30) @(negedge iclk);
    check("t5_idle_busy", 32'(bus.obusy), 0);
    check("t5_fifo_kept", 32'(len_fifo.size()), 1);
    bus.ien = 1'b1;
    for (i = 0; i < 50; i++) begin
      @(negedge iclk);
      if (bus.otx_en) break;
    end
    check("t5_started", 32'(i < 50), 1);
    repeat (PRE + 1 + 10) @(negedge iclk);
    push_len(30);
    bus.ien = 1'b0;
    for (i = 0; i < 200; i++) begin
      @(negedge iclk);
      if (bus.oframe_done) break;
    end
    check("t5_frame_completed", 32'(i < 200), 1);
    repeat (40) @(negedge iclk);
    check("t5_no_restart_busy", 32'(bus.obusy), 0);
    check("t5_no_restart_fifo", 32'(len_fifo.size()), 1);
    bus.ien = 1'b1;
    drain(300, "t5_drain");

    // Reset in the middle of DATA abandons the frame immediately
    push_len(100);
    for (i = 0; i < 50; i++) begin
      @(negedge iclk);
      if (bus.otx_en) break;
    end
    check("t6_started", 32'(i < 50), 1);
    repeat (PRE + 1 + 20) @(negedge iclk);
    check("t6_in_data", 32'(bus.otx_en), 1);
    #2;
    i_rst = 1'b1;
    #1;
    check("t6_otx_en_async", 32'(bus.otx_en), 0);
    check("t6_optr_async", 32'(bus.optr_rd), 0);
    check("t6_obusy_async", 32'(bus.obusy), 0);
    check("t6_fifo_popped", 32'(len_fifo.size()), 0);
    flush_model();
    repeat (2) @(negedge iclk);
    i_rst = 1'b0;

    // Boundary lengths then randomized traffic with ien toggling
    push_len(1536);
    push_len(1537);
    push_len(1);
    drain(3000, "t7_boundary_drain");
    for (int f = 0; f < 25; f++) begin
      repeat ($urandom_range(0, 30)) @(negedge iclk);
      bus.ien = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 9);
      if (r == 0) push_len(0);
      else if (r == 1) push_len($urandom_range(MAXLEN + 1, 2047));
      else push_len($urandom_range(1, 120));
    end
    bus.ien = 1'b1;
    drain(20000, "t8_random_drain");
    check("t8_final_ptr", 32'(bus.optr_rd), 32'(model_rptr));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
